// File: rtl/one_generator_pkg.sv
// Shared definitions for the one_generator slice: default sizes and the
// control-unit state encoding.
package one_generator_pkg;
    localparam int WIDTH = 16;
    localparam int CW    = 5;

    // 2'b11 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FILL    = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;
endpackage

// File: rtl/one_generator_if.sv
// Request/result bundle for one_generator. Handshake: a request is accepted on
// any rising edge with i_start=1 while not busy; o_data/o_err are valid only while o_done=1.
interface one_generator_if
    import one_generator_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_CW    = CW
);
    logic               i_start;
    logic [P_CW-1:0]    i_count;
    logic [P_WIDTH-1:0] o_data;
    logic               o_busy;
    logic               o_done;
    logic               o_err;

    modport master (
        output i_start, i_count,
        input  o_data, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_count,
        output o_data, o_busy, o_done, o_err
    );
endinterface

// File: rtl/one_generator_datapath.sv
// Shifter and remaining-count down-counter: shifts a 1 in per step and counts
// down a saturated copy of the requested ones-count.
module one_generator_datapath
    import one_generator_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_CW    = CW
) (
    input  logic               i_clk,
    input  logic               i_rst_,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [P_CW-1:0]    i_count,
    output logic [P_WIDTH-1:0] o_data,
    output logic               o_err,
    output logic               o_rem_zero
);
    localparam logic [P_CW-1:0] WIDTH_C = P_CW'(P_WIDTH);

    logic [P_CW-1:0] rem;
    logic            over;

    // Clamping rem at WIDTH bounds the number of shifts, so the word never wraps.
    assign over       = (i_count > WIDTH_C);
    assign o_rem_zero = (rem == '0);

    always_ff @(posedge i_clk or negedge i_rst_) begin
        if (!i_rst_) begin
            o_data <= '0;
            rem    <= '0;
            o_err  <= 1'b0;
        end else if (i_load) begin
            o_data <= '0;
            rem    <= over ? WIDTH_C : i_count;
            o_err  <= over;
        end else if (i_shift) begin
            o_data <= {o_data[P_WIDTH-2:0], 1'b1};
            rem    <= rem - 1'b1;
        end
    end
endmodule

// File: rtl/one_generator.sv
// Thermometer-code generator: builds a word with exactly N ones, LSB-aligned,
// one bit per cycle. Control FSM here; shifting and counting in the datapath.
module one_generator
    import one_generator_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_CW    = CW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_,
    one_generator_if.slave       bus,
    output state_t               o_state
);
    state_t         state;
    logic           load;
    logic           shift;
    logic           rem_zero;
    logic           busy_q;
    logic           done_q;
    logic [P_WIDTH-1:0] data;
    logic           err;

    // A new request is taken from any state except FILL.
    assign load  = (state != ST_FILL) && bus.i_start;
    assign shift = (state == ST_FILL) && !rem_zero;

    always_ff @(posedge i_clk or negedge i_rst_) begin
        if (!i_rst_) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (rem_zero) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.i_start) begin
                        state  <= ST_FILL;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    if (bus.i_start) begin
                        state  <= ST_FILL;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    one_generator_datapath #(
        .P_WIDTH (P_WIDTH),
        .P_CW    (P_CW)
    ) u_datapath (
        .i_clk      (i_clk),
        .i_rst_     (i_rst_),
        .i_load     (load),
        .i_shift    (shift),
        .i_count    (bus.i_count),
        .o_data     (data),
        .o_err      (err),
        .o_rem_zero (rem_zero)
    );

    assign bus.o_data = data;
    assign bus.o_err  = err;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign o_state    = state;
endmodule

// File: tb/tb_one_generator.sv
// Randomized scoreboard bench for one_generator against a thermometer-code
// reference model.
module tb_one_generator;
  import one_generator_pkg::*;

  logic   i_clk;
  logic   i_rst_;
  state_t o_state;

  one_generator_if bus ();

  one_generator dut (
    .i_clk   (i_clk),
    .i_rst_  (i_rst_),
    .bus     (bus),
    .o_state (o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;
  int start_edge = 0;

  logic [16:0] exp_q[$];
  int          lat_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: N ones LSB-aligned, N clamped at 16, err when N > 16
  function automatic logic [16:0] model(input int n);
    int          k;
    logic [31:0] w;
    k = (n > 16) ? 16 : n;
    w = (32'd1 << k) - 32'd1;
    return {(n > 16), w[15:0]};
  endfunction

  function automatic int model_lat(input int n);
    return ((n > 16) ? 16 : n) + 1;
  endfunction

  // driver tasks
  task automatic do_req(input int n);
    @(negedge i_clk);
    bus.i_start = 1'b1;
    bus.i_count = n[4:0];
    start_edge  = cyc + 1;
    exp_q.push_back(model(n));
    lat_q.push_back(model_lat(n));
    @(negedge i_clk);
    bus.i_start = 1'b0;
    bus.i_count = 5'($urandom_range(0, 31));
    chk("busy_after_start", {31'd0, bus.o_busy}, 32'd1);
    chk("done_after_start", {31'd0, bus.o_done}, 32'd0);
    chk("state_after_start", {30'd0, o_state}, {30'd0, ST_FILL});
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge i_clk);
      #1;
      t = t + 1;
    end
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL done_timeout: got no o_done within %0d cycles, required one", t);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // monitor / scoreboard
  logic        prev_done = 1'b0;
  logic        prev_busy = 1'b0;
  int          busy_cnt = 0;
  logic [16:0] last_exp = '0;

  always @(negedge i_clk) begin
    if (!i_rst_) begin
      prev_done = 1'b0;
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (bus.o_busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
      if (bus.o_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL unexpected_done: got o_done=1 with no pending request");
        end else begin
          logic [16:0] e;
          int          l;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          last_exp = e;
          chk("data", {16'd0, bus.o_data}, {16'd0, e[15:0]});
          chk("err", {31'd0, bus.o_err}, {31'd0, e[16]});
          chk("latency", cyc - start_edge, l);
          chk("busy_cycles", busy_cnt, l);
        end
      end
      prev_done = bus.o_done;
      prev_busy = bus.o_busy;
    end
  end

  task automatic chk_hold();
    repeat (3) @(negedge i_clk);
    chk("hold_data", {16'd0, bus.o_data}, {16'd0, last_exp[15:0]});
    chk("hold_done", {31'd0, bus.o_done}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, {16'd0, bus.o_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.o_err}, 32'd0);
    chk({tag, "_state"}, {30'd0, o_state}, {30'd0, ST_IDLE});
  endtask

  initial begin
    i_rst_      = 1'b1;
    bus.i_start = 1'b0;
    bus.i_count = '0;
    #3 i_rst_ = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst_ = 1'b1;

    // directed cases
    do_req(5);  wait_idle(); chk_hold();
    do_req(0);  wait_idle();
    do_req(16); wait_idle();
    do_req(20); wait_idle();

    // start pulse during FILL must be ignored
    do_req(8);
    repeat (2) @(negedge i_clk);
    bus.i_start = 1'b1;
    bus.i_count = 5'd2;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    wait_idle();
    chk_hold();

    // restart straight out of DONE
    do_req(3); wait_idle();

    // asynchronous reset mid-FILL
    do_req(10);
    repeat (3) @(negedge i_clk);
    #2 i_rst_ = 1'b0;
    #1 chk_zero("async_reset");
    exp_q.delete();
    lat_q.delete();
    @(negedge i_clk);
    i_rst_ = 1'b1;
    do_req(1); wait_idle();

    // randomized requests, some back-to-back from DONE
    for (int i = 0; i < 20; i++) begin
      do_req(int'($urandom_range(0, 31)));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end

    repeat (2) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
